// File: rtl/controlador_calculadora.sv
// Sequencing controller for an 8-bit calculator built around an external adder/subtractor.
// Define CALC_MUL_EN to include the shift-add multiplier; otherwise MUL completes with err=1.
module controlador_calculadora (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic       dp_sel,
  input  logic [7:0] dp_result,
  input  logic       dp_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       carry,
  output logic       ovf,
  output logic       zero,
  output logic       err,
  output logic       busy
);

  // state  | meaning
  // S_IDLE | waiting for a request, in_ready high
  // S_EXEC | single-cycle add/sub/compare through the datapath
  // S_MUL  | eight shift-add iterations (only with CALC_MUL_EN)
  // S_DONE | result valid, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef CALC_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic [7:0] a_q, b_q;
  logic       ovf_w;

`ifdef CALC_MUL_EN
  logic [7:0] p_q, m_q, q_q;
  logic [2:0] cnt_q;
  logic       m_lost_q, c_acc_q;
  logic [7:0] p_nxt;
  logic       c_nxt;

  assign p_nxt = q_q[0] ? dp_result : p_q;
  // A set bit of Q meeting a bit already shifted out of M means the product exceeds 255.
  assign c_nxt = c_acc_q | (q_q[0] & (dp_cout | m_lost_q));
`endif

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // Subtraction inverts B, so its effective sign flips before the overflow test.
  assign ovf_w = (a_q[7] == (b_q[7] ^ op_q[0])) && (dp_result[7] != a_q[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dp_a      = 8'h00;
    dp_b      = 8'h00;
    dp_sel    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef CALC_MUL_EN
          state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        dp_a      = a_q;
        dp_b      = b_q;
        dp_sel    = op_q[0];
        state_nxt = S_DONE;
      end
`ifdef CALC_MUL_EN
      S_MUL: begin
        dp_a = p_q;
        dp_b = m_q;
        if (cnt_q == 3'd0) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result   <= 8'h00;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
`ifdef CALC_MUL_EN
      p_q      <= 8'h00;
      m_q      <= 8'h00;
      q_q      <= 8'h00;
      cnt_q    <= 3'd0;
      m_lost_q <= 1'b0;
      c_acc_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            a_q      <= operand_a;
            b_q      <= operand_b;
`ifdef CALC_MUL_EN
            p_q      <= 8'h00;
            m_q      <= operand_a;
            q_q      <= operand_b;
            cnt_q    <= 3'd7;
            m_lost_q <= 1'b0;
            c_acc_q  <= 1'b0;
`endif
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              result <= dp_result;
              carry  <= dp_cout;
              ovf    <= ovf_w;
              zero   <= (dp_result == 8'h00);
              err    <= 1'b0;
            end
            OP_CMP: begin
              result <= 8'h00;
              carry  <= dp_cout;
              ovf    <= ovf_w;
              zero   <= (a_q == b_q);
              err    <= 1'b0;
            end
            default: begin
              result <= 8'h00;
              carry  <= 1'b0;
              ovf    <= 1'b0;
              zero   <= 1'b0;
              err    <= 1'b1;
            end
          endcase
        end
`ifdef CALC_MUL_EN
        S_MUL: begin
          p_q      <= p_nxt;
          m_q      <= {m_q[6:0], 1'b0};
          q_q      <= {1'b0, q_q[7:1]};
          m_lost_q <= m_lost_q | m_q[7];
          c_acc_q  <= c_nxt;
          cnt_q    <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            result <= p_nxt;
            carry  <= c_nxt;
            zero   <= (p_nxt == 8'h00);
            ovf    <= 1'b0;
            err    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_calculadora.sv
// Directed bench for controlador_calculadora with a behavioural somador_subtrator model.
module tb_controlador_calculadora;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op = 2'b00;
  logic [7:0] operand_a = 8'h00, operand_b = 8'h00;
  logic [7:0] dp_a, dp_b, dp_result;
  logic       dp_sel, dp_cout;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       carry, ovf, zero, err, busy;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  assign {dp_cout, dp_result} = dp_sel ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1)
                                       : ({1'b0, dp_a} + {1'b0, dp_b});

  controlador_calculadora dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dp_a(dp_a), .dp_b(dp_b),
    .dp_sel(dp_sel), .dp_result(dp_result), .dp_cout(dp_cout), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .ovf(ovf), .zero(zero),
    .err(err), .busy(busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue a request and wait (bounded) for out_valid; lat counts edges after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int l);
    @(negedge clk);
    check("in_ready_before", 16'(in_ready), 16'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = 8'h5A; operand_b = 8'hA5; op = 2'b01;
    check("busy_after_accept", 16'(busy), 16'd1);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_done", 16'(in_ready), 16'd1);
    check("out_valid_after_done", 16'(out_valid), 16'd0);
  endtask

  initial begin
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_result", 16'(result), 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // ADD 200,100
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; operand_a = 8'd200; operand_b = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("add_exec_dp_a", 16'(dp_a), 16'd200);
    check("add_exec_dp_b", 16'(dp_b), 16'd100);
    check("add_exec_dp_sel", 16'(dp_sel), 16'd0);
    @(posedge clk); #1;
    check("add_out_valid", 16'(out_valid), 16'd1);
    check("add_result", 16'(result), 16'h2C);
    check("add_flags", {12'd0, carry, ovf, zero, err}, 16'b1000);
    check("done_dp_a", 16'(dp_a), 16'd0);
    release_result();

    run_op(2'b01, 8'd5, 8'd7, lat);
    check("sub1_lat", 16'(lat), 16'd1);
    check("sub1_result", 16'(result), 16'hFE);
    check("sub1_flags", {12'd0, carry, ovf, zero, err}, 16'b0000);
    release_result();

    run_op(2'b01, 8'h80, 8'h01, lat);
    check("sub2_result", 16'(result), 16'h7F);
    check("sub2_flags", {12'd0, carry, ovf, zero, err}, 16'b1100);
    release_result();

    run_op(2'b11, 8'd9, 8'd9, lat);
    check("cmp1_result", 16'(result), 16'h00);
    check("cmp1_flags", {12'd0, carry, ovf, zero, err}, 16'b1010);
    release_result();

    run_op(2'b11, 8'd3, 8'd9, lat);
    check("cmp2_result", 16'(result), 16'h00);
    check("cmp2_flags", {12'd0, carry, ovf, zero, err}, 16'b0000);
    release_result();

`ifdef CALC_MUL_EN
    run_op(2'b10, 8'd13, 8'd11, lat);
    check("mul1_lat", 16'(lat), 16'd8);
    check("mul1_result", 16'(result), 16'h8F);
    check("mul1_flags", {12'd0, carry, ovf, zero, err}, 16'b0000);
    release_result();

    run_op(2'b10, 8'd16, 8'd16, lat);
    check("mul2_lat", 16'(lat), 16'd8);
    check("mul2_result", 16'(result), 16'h00);
    check("mul2_flags", {12'd0, carry, ovf, zero, err}, 16'b1010);
    release_result();
`else
    run_op(2'b10, 8'd13, 8'd11, lat);
    check("mul_dis_lat", 16'(lat), 16'd1);
    check("mul_dis_result", 16'(result), 16'h00);
    check("mul_dis_flags", {12'd0, carry, ovf, zero, err}, 16'b0001);
    release_result();
`endif

    // Stall in DONE with ignored requests
    run_op(2'b00, 8'd1, 8'd2, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0]; op = 2'b01; operand_a = 8'hFF; operand_b = 8'h01;
      @(posedge clk); #1;
      check("hold_result", 16'(result), 16'h03);
      check("hold_valid_ready", {14'd0, out_valid, in_ready}, 16'b10);
    end
    @(negedge clk); in_valid = 1'b0;
    release_result();
    @(posedge clk); #1;
    check("hold_no_accept", 16'(busy), 16'd0);

    // Abort an operation with reset, mid-iteration when the multiplier exists
    @(negedge clk);
`ifdef CALC_MUL_EN
    in_valid = 1'b1; op = 2'b10; operand_a = 8'd13; operand_b = 8'd11;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
`else
    in_valid = 1'b1; op = 2'b00; operand_a = 8'd7; operand_b = 8'd8;
    @(posedge clk); #1; in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_result", 16'(result), 16'd0);
    check("abort_dp", {dp_a, dp_b}, 16'd0);
    check("abort_flags", {12'd0, carry, ovf, zero, err}, 16'b0000);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) check("abort_no_valid", 16'(out_valid), 16'd0);
    end
    check("abort_idle", 16'(in_ready), 16'd1);

    run_op(2'b00, 8'd1, 8'd1, lat);
    check("post_rst_lat", 16'(lat), 16'd1);
    check("post_rst_result", 16'(result), 16'h02);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_calculadora.md
CONTROLADOR_CALCULADORA -- requirements
Module: controlador_calculadora

Interface
Parameters: none; datapath width fixed at 8 bits.
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  request present on op/operand_a/operand_b.
REQ-004 in_ready  out  1  controller accepts a request this cycle.
REQ-005 op  in  2  00 ADD, 01 SUB, 10 MUL, 11 CMP.
REQ-006 operand_a, operand_b  in  8 each  request operands, unsigned bit patterns.
REQ-007 dp_a, dp_b  out  8 each  operands driven to external somador_subtrator.
REQ-008 dp_sel  out  1  0 add, 1 subtract, to somador_subtrator.
REQ-009 dp_result  in  8  somador_subtrator sum/difference.
REQ-010 dp_cout  in  1  somador_subtrator carry-out (1 = no borrow on SUB).
REQ-011 out_valid  in/out  out  1  result registers valid.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 result  out  8  operation result.
REQ-014 carry, ovf, zero, err  out  1 each  status flags.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States IDLE, EXEC, MUL, DONE; in_ready SHALL equal (state==IDLE).
REQ-017 Accept on rising edge with in_valid&in_ready: latch op, operand_a, operand_b; ADD/SUB/CMP -> EXEC, MUL -> MUL.
REQ-018 EXEC (one cycle): dp_a=A, dp_b=B, dp_sel=op[0] for SUB/CMP, 0 for ADD; at end of cycle capture flags, go DONE; out_valid high first cycle after EXEC (1 cycle after accept edge).
REQ-019 ADD/SUB: result=dp_result, carry=dp_cout, ovf = signed overflow (operand sign equal after dp_b adjustment, result sign differs), zero=(dp_result==0), err=0.
REQ-020 CMP: result=8'h00, carry=dp_cout (A>=B), zero=(A==B), ovf as SUB, err=0.
REQ-021 MUL: exactly 8 iteration cycles, shift-add using datapath only for addition: P=0, M=A, Q=B; each cycle dp_a=P, dp_b=M, dp_sel=0; if Q[0] P<=dp_result; M<<=1; Q>>=1.
REQ-022 MUL carry=1 iff true 16-bit product >255 (any accumulated dp_cout, or Q[0]=1 after a 1 bit was shifted out of M); result=P low 8 bits; zero=(P==0); ovf=0; err=0.
REQ-023 MUL out_valid high first cycle after 8th iteration edge (8 cycles after accept edge); no early termination.
REQ-024 DONE: result and flags held stable; leave to IDLE on edge with out_valid&out_ready; no new request accepted in same cycle.
REQ-025 dp_a, dp_b, dp_sel SHALL be 0 in IDLE and DONE.
REQ-026 in_valid ignored outside IDLE; operand inputs may change freely after acceptance.

Reset
REQ-027 rst_n low, any state including mid-MUL: state IDLE immediately; result, carry, ovf, zero, err, out_valid, busy, dp_* = 0; in_ready=1 after rst_n released.
REQ-028 No partial result from an aborted operation SHALL appear after reset.

Configuration
REQ-029 Macro CALC_MUL_EN defined: MUL behaves per REQ-021..023.
REQ-030 CALC_MUL_EN undefined: MUL state and iteration logic absent; op 10 goes to EXEC, completes with result=8'h00, err=1, carry=ovf=zero=0, latency as ADD.

Verification
REQ-031 ADD 200,100 -> 1 cycle after accept out_valid=1, result=0x2C, carry=1, ovf=0, zero=0.
REQ-032 SUB 5,7 -> result=0xFE, carry=0; SUB 0x80,0x01 -> result=0x7F, ovf=1.
REQ-033 CMP 9,9 -> result=0x00, zero=1, carry=1; CMP 3,9 -> carry=0, zero=0.
REQ-034 MUL 13,11 -> out_valid exactly 8 cycles after accept, result=0x8F, carry=0; MUL 16,16 -> result=0x00, carry=1, zero=1; without CALC_MUL_EN MUL 13,11 -> err=1, result=0x00.
REQ-035 ADD then hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 Assert rst_n=0 in 4th MUL iteration -> outputs 0 immediately, out_valid never rises for that request; next ADD 1,1 -> result=0x02.
